mux_arbiter: RTL and testbench

Two-requester round-robin arbiter that owns the select line of the 2:1 data mux and shares its single output between two sources. Each source raises a request; the arbiter grants one at a time, drives the mux select to match, bounds each tenure with a hold counter, and presents the selected data bit with a valid flag. The arbiter sits directly in front of the gate-level 2:1 mux and is the only driver of that mux's select input.

---
 rtl/mux_arbiter_if.sv | 23 ++
 rtl/mux_arbiter.sv | 94 +++++++++
 tb/tb_mux_arbiter.sv | 255 +++++++++++++++++++++++++
 3 files changed

// File: rtl/mux_arbiter_if.sv
// Request/data/grant bundle between the two mux sources and the arbiter.
// The arbiter takes the slave side; sources (or a bench) take the master side.
interface mux_arbiter_if;
    logic R0;
    logic R1;
    logic I0;
    logic I1;
    logic G0;
    logic G1;
    logic S;
    logic Y;
    logic VALID;

    modport slave (
        input  R0, R1, I0, I1,
        output G0, G1, S, Y, VALID
    );

    modport master (
        output R0, R1, I0, I1,
        input  G0, G1, S, Y, VALID
    );
endinterface

// File: rtl/mux_arbiter.sv
// Two-source round-robin arbiter that owns the 2:1 mux select line and bounds
// each tenure with a hold counter while the other source is waiting.
//
// state | meaning
// IDLE  | no grant, mux output forced low
// GNT0  | source 0 owns the mux, S=0
// GNT1  | source 1 owns the mux, S=1
module mux_arbiter #(
    parameter int HOLD_MAX = 4,
    parameter int HOLD_W   = 3
) (
    input  logic          Clk,
    input  logic          Resetb,
    mux_arbiter_if.slave  bus
);

    typedef enum logic [2:0] {
        IDLE = 3'b001,
        GNT0 = 3'b010,
        GNT1 = 3'b100
    } state_t;

    localparam logic [HOLD_W-1:0] CNT_LAST = HOLD_W'(HOLD_MAX - 1);

    state_t            state;
    state_t            state_nxt;
    logic [HOLD_W-1:0] cnt;
    logic [HOLD_W-1:0] cnt_nxt;
    logic              last;
    logic              last_nxt;
    logic              req_own;
    logic              req_oth;

    // LAST resets to 1 so source 0 wins the first tie.
    always_ff @(posedge Clk) begin
        if (!Resetb) begin
            state <= IDLE;
            cnt   <= '0;
            last  <= 1'b1;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            last  <= last_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        last_nxt  = last;
        req_own   = (state == GNT1) ? bus.R1 : bus.R0;
        req_oth   = (state == GNT1) ? bus.R0 : bus.R1;
        unique case (state)
            IDLE: begin
                cnt_nxt = '0;
                if (bus.R0 && bus.R1) begin
                    if (last) state_nxt = GNT0;
                    else      state_nxt = GNT1;
                end else if (bus.R0) begin
                    state_nxt = GNT0;
                end else if (bus.R1) begin
                    state_nxt = GNT1;
                end
            end
            GNT0, GNT1: begin
                // Voluntary release or expired tenure both hand over without a gap.
                if (!req_own || (req_oth && cnt == CNT_LAST)) begin
                    last_nxt = (state == GNT1);
                    cnt_nxt  = '0;
                    if (req_oth) begin
                        if (state == GNT1) state_nxt = GNT0;
                        else               state_nxt = GNT1;
                    end else begin
                        state_nxt = IDLE;
                    end
                end else if (cnt != CNT_LAST) begin
                    cnt_nxt = cnt + HOLD_W'(1);
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    assign bus.G0    = (state == GNT0);
    assign bus.G1    = (state == GNT1);
    assign bus.S     = (state == GNT1);
    assign bus.VALID = (state == GNT0) || (state == GNT1);
    assign bus.Y     = (state == GNT1) ? bus.I1 :
                       (state == GNT0) ? bus.I0 : 1'b0;

endmodule

// File: tb/tb_mux_arbiter.sv
// Scoreboard bench for mux_arbiter: a behavioural model queues the expected
// grant after each driven cycle and each scenario task pops and compares.
module tb_mux_arbiter;

    localparam int HOLD_MAX = 4;

    logic Clk    = 1'b0;
    logic Resetb = 1'b0;
    int   errors = 0;
    int   checks = 0;

    mux_arbiter_if bus ();
    mux_arbiter_if bus1 ();

    mux_arbiter #(.HOLD_MAX(HOLD_MAX), .HOLD_W(3)) u_dut (
        .Clk    (Clk),
        .Resetb (Resetb),
        .bus    (bus)
    );

    // Second instance at the tightest hold limit, fed the same requests.
    mux_arbiter #(.HOLD_MAX(1), .HOLD_W(3)) u_dut1 (
        .Clk    (Clk),
        .Resetb (Resetb),
        .bus    (bus1)
    );

    assign bus1.R0 = bus.R0;
    assign bus1.R1 = bus.R1;
    assign bus1.I0 = bus.I0;
    assign bus1.I1 = bus.I1;

    always #5 Clk = ~Clk;

    logic [1:0] exp_q[$];   // {G1, G0}
    int m_own  = -1;        // -1 idle, 0 or 1 = holder
    int m_cnt  = 0;
    int m_last = 1;

    function automatic logic [4:0] got_vec();
        return {bus.G1, bus.G0, bus.S, bus.VALID, bus.Y};
    endfunction

    function automatic logic [4:0] want_vec(input logic [1:0] e);
        logic y;
        y = e[1] ? bus.I1 : (e[0] ? bus.I0 : 1'b0);
        return {e[1], e[0], e[1], e[1] | e[0], y};
    endfunction

    // Drive one cycle, advance the model, queue its prediction, then sample #1 after the edge.
    task automatic step(input logic rstb, input logic r0, input logic r1);
        int mine;
        int other;
        Resetb = rstb;
        bus.R0 = r0;
        bus.R1 = r1;
        if (!rstb) begin
            m_own  = -1;
            m_cnt  = 0;
            m_last = 1;
        end else if (m_own < 0) begin
            m_cnt = 0;
            if (r0 && r1)  m_own = (m_last == 1) ? 0 : 1;
            else if (r0)   m_own = 0;
            else if (r1)   m_own = 1;
        end else begin
            mine  = (m_own == 0) ? int'(r0) : int'(r1);
            other = (m_own == 0) ? int'(r1) : int'(r0);
            if (mine == 0) begin
                m_last = m_own;
                m_own  = (other != 0) ? 1 - m_own : -1;
                m_cnt  = 0;
            end else if (other != 0 && m_cnt == HOLD_MAX - 1) begin
                m_last = m_own;
                m_own  = 1 - m_own;
                m_cnt  = 0;
            end else if (m_cnt < HOLD_MAX - 1) begin
                m_cnt = m_cnt + 1;
            end
        end
        exp_q.push_back({m_own == 1, m_own == 0});
        @(posedge Clk);
        #1;
    endtask

    task automatic test_reset();
        logic [1:0] e;
        bus.I0 = 1'b1;
        bus.I1 = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b1, 1'b1);
            e = exp_q.pop_front();
            checks++;
            if (got_vec() !== 5'b00000 || want_vec(e) !== 5'b00000) begin
                errors++;
                $display("FAIL reset_hold cyc=%0d got=%b want=00000", i, got_vec());
            end
        end
        step(1'b1, 1'b1, 1'b1);
        e = exp_q.pop_front();
        checks++;
        if (got_vec() !== want_vec(e) || bus.G0 !== 1'b1) begin
            errors++;
            $display("FAIL reset_release got=%b want=%b", got_vec(), want_vec(e));
        end
        step(1'b1, 1'b0, 1'b0);
        e = exp_q.pop_front();
        checks++;
        if (got_vec() !== want_vec(e)) begin
            errors++;
            $display("FAIL reset_idle got=%b want=%b", got_vec(), want_vec(e));
        end
    endtask

    task automatic test_single();
        logic [1:0] e;
        for (int i = 0; i < 10; i++) begin
            bus.I1 = i[0];
            bus.I0 = 1'b0;
            step(1'b1, 1'b0, 1'b1);
            e = exp_q.pop_front();
            checks++;
            if (got_vec() !== want_vec(e) || bus.G1 !== 1'b1) begin
                errors++;
                $display("FAIL single_hold cyc=%0d got=%b want=%b", i, got_vec(), want_vec(e));
            end
            bus.I1 = ~bus.I1;
            #1;
            checks++;
            if (bus.Y !== bus.I1) begin
                errors++;
                $display("FAIL single_y_pass cyc=%0d got=%b want=%b", i, bus.Y, bus.I1);
            end
        end
        step(1'b1, 1'b0, 1'b0);
        e = exp_q.pop_front();
        checks++;
        if (got_vec() !== want_vec(e) || bus.VALID !== 1'b0) begin
            errors++;
            $display("FAIL single_release got=%b want=%b", got_vec(), want_vec(e));
        end
    endtask

    task automatic test_contention();
        logic [1:0] e;
        logic [1:0] alt;
        bus.I0 = 1'b0;
        bus.I1 = 1'b1;
        for (int i = 0; i < 16; i++) begin
            step(1'b1, 1'b1, 1'b1);
            e = exp_q.pop_front();
            checks++;
            if (got_vec() !== want_vec(e) || bus.VALID !== 1'b1) begin
                errors++;
                $display("FAIL contention cyc=%0d got=%b want=%b", i, got_vec(), want_vec(e));
            end
            alt = (i % 2 == 0) ? 2'b01 : 2'b10;
            checks++;
            if ({bus1.G1, bus1.G0} !== alt) begin
                errors++;
                $display("FAIL hold_one_alt cyc=%0d got=%b want=%b", i, {bus1.G1, bus1.G0}, alt);
            end
        end
        step(1'b1, 1'b0, 1'b0);
        e = exp_q.pop_front();
        checks++;
        if (got_vec() !== want_vec(e)) begin
            errors++;
            $display("FAIL contention_release got=%b want=%b", got_vec(), want_vec(e));
        end
    endtask

    task automatic test_early_release();
        logic [1:0] e;
        logic [2:0] r [9] = '{3'b110, 3'b111, 3'b101, 3'b111, 3'b111,
                              3'b111, 3'b111, 3'b111, 3'b100};
        for (int i = 0; i < 9; i++) begin
            step(r[i][2], r[i][1], r[i][0]);
            e = exp_q.pop_front();
            checks++;
            if (got_vec() !== want_vec(e)) begin
                errors++;
                $display("FAIL early_release cyc=%0d got=%b want=%b", i, got_vec(), want_vec(e));
            end
        end
    endtask

    task automatic test_tie();
        logic [1:0] e;
        logic [1:0] r [6]    = '{2'b01, 2'b00, 2'b11, 2'b00, 2'b11, 2'b00};
        logic [1:0] fixed [6] = '{2'b10, 2'b00, 2'b01, 2'b00, 2'b10, 2'b00};
        for (int i = 0; i < 6; i++) begin
            step(1'b1, r[i][1], r[i][0]);
            e = exp_q.pop_front();
            checks++;
            if ({bus.G1, bus.G0} !== fixed[i] || got_vec() !== want_vec(e)) begin
                errors++;
                $display("FAIL tie cyc=%0d got=%b want=%b", i, {bus.G1, bus.G0}, fixed[i]);
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [1:0] e;
        logic [2:0] r [6] = '{3'b101, 3'b101, 3'b101, 3'b011, 3'b111, 3'b100};
        bus.I0 = 1'b1;
        bus.I1 = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step(r[i][2], r[i][1], r[i][0]);
            e = exp_q.pop_front();
            checks++;
            if (got_vec() !== want_vec(e)) begin
                errors++;
                $display("FAIL reset_mid cyc=%0d got=%b want=%b", i, got_vec(), want_vec(e));
            end
        end
    endtask

    task automatic test_random();
        logic [1:0] e;
        for (int i = 0; i < 300; i++) begin
            bus.I0 = 1'($urandom_range(0, 1));
            bus.I1 = 1'($urandom_range(0, 1));
            step(($urandom_range(0, 31) != 0), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            e = exp_q.pop_front();
            checks++;
            if (got_vec() !== want_vec(e)) begin
                errors++;
                $display("FAIL random cyc=%0d got=%b want=%b", i, got_vec(), want_vec(e));
            end
            checks++;
            if (bus1.G0 === 1'b1 && bus1.G1 === 1'b1) begin
                errors++;
                $display("FAIL hold_one_overlap cyc=%0d got=11 want=not 11", i);
            end
        end
    endtask

    initial begin
        bus.R0 = 1'b0;
        bus.R1 = 1'b0;
        bus.I0 = 1'b0;
        bus.I1 = 1'b0;
        test_reset();
        test_single();
        test_contention();
        test_early_release();
        test_tie();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
